// File: rtl/axis_operand_pairer_if.sv
// AXI-Stream style channel: tdata/tvalid/tready/tlast.
// Handshake: a beat transfers on a rising clock edge where tvalid && tready.
// The master holds tdata/tlast stable while tvalid=1 and tready=0.
interface axis_operand_pairer_if #(
    parameter int W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_operand_pairer.sv
// Packs two consecutive c_WIDTH-bit operands into one 2*c_WIDTH-bit word,
// first operand in the low half. A lone last operand of an odd-length
// packet is zero-padded (c_PAD_ODD=1) or discarded with an odd_drop pulse.
module axis_operand_pairer #(
    parameter int c_WIDTH   = 8,
    parameter bit c_PAD_ODD = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_operand_pairer_if.slave   s_axis,
    axis_operand_pairer_if.master  m_axis,
    output logic                   odd_drop,
    output logic                   dbg_state_o
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_WIDTH-1:0]   lo_q, lo_d;
    logic [2*c_WIDTH-1:0] m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_last_q, m_last_d;
    logic                 odd_drop_q, odd_drop_d;

    logic free;
    logic s_ready;
    logic accept;

    // Output slot is free when empty or draining this cycle; the same rule
    // applies in both states, and input is refused while reset is asserted.
    assign free    = !m_valid_q || m_axis.tready;
    assign s_ready = free && !rst;
    assign accept  = s_axis.tvalid && s_ready;

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;
    assign odd_drop      = odd_drop_q;
    assign dbg_state_o   = state_q;

    // Next-state and output-register logic: drain first, then any new load wins.
    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        odd_drop_d = 1'b0;

        if (m_valid_q && m_axis.tready) begin
            m_valid_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                ST_EMPTY: begin
                    if (!s_axis.tlast) begin
                        lo_d    = s_axis.tdata;
                        state_d = ST_HALF;
                    end else if (c_PAD_ODD) begin
                        m_data_d  = {{c_WIDTH{1'b0}}, s_axis.tdata};
                        m_last_d  = 1'b1;
                        m_valid_d = 1'b1;
                    end else begin
                        odd_drop_d = 1'b1;
                    end
                end
                ST_HALF: begin
                    m_data_d  = {s_axis.tdata, lo_q};
                    m_last_d  = s_axis.tlast;
                    m_valid_d = 1'b1;
                    state_d   = ST_EMPTY;
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and output registers; reset discards any held half-pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            lo_q       <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            odd_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            odd_drop_q <= odd_drop_d;
        end
    end

endmodule

// File: tb/tb_axis_operand_pairer.sv
// Directed bench for axis_operand_pairer: one instance pads lone operands,
// a second instance drops them; both see the same input stream.
module tb_axis_operand_pairer;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [W-1:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic         m_tready = 1'b1;

    int total = 0;
    int bad   = 0;

    logic odd_drop_p, odd_drop_d;
    logic state_p, state_d;

    axis_operand_pairer_if #(.W(W))   s_if_p ();
    axis_operand_pairer_if #(.W(2*W)) m_if_p ();
    axis_operand_pairer_if #(.W(W))   s_if_d ();
    axis_operand_pairer_if #(.W(2*W)) m_if_d ();

    assign s_if_p.tdata  = s_tdata;
    assign s_if_p.tvalid = s_tvalid;
    assign s_if_p.tlast  = s_tlast;
    assign m_if_p.tready = m_tready;
    assign s_if_d.tdata  = s_tdata;
    assign s_if_d.tvalid = s_tvalid;
    assign s_if_d.tlast  = s_tlast;
    assign m_if_d.tready = m_tready;

    axis_operand_pairer #(.c_WIDTH(W), .c_PAD_ODD(1'b1)) dut_p (
        .clk         (clk),
        .rst         (rst),
        .s_axis      (s_if_p.slave),
        .m_axis      (m_if_p.master),
        .odd_drop    (odd_drop_p),
        .dbg_state_o (state_p)
    );

    axis_operand_pairer #(.c_WIDTH(W), .c_PAD_ODD(1'b0)) dut_d (
        .clk         (clk),
        .rst         (rst),
        .s_axis      (s_if_d.slave),
        .m_axis      (m_if_d.master),
        .odd_drop    (odd_drop_d),
        .dbg_state_o (state_d)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1;
        step(); step();
        total++; if (m_if_p.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", m_if_p.tvalid); end
        total++; if (m_if_p.tdata !== 16'h0000) begin bad++; $display("FAIL reset_tdata got=%h exp=0000", m_if_p.tdata); end
        total++; if (m_if_p.tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b exp=0", m_if_p.tlast); end
        total++; if (odd_drop_d !== 1'b0) begin bad++; $display("FAIL reset_odd_drop got=%b exp=0", odd_drop_d); end
        total++; if (s_if_p.tready !== 1'b0) begin bad++; $display("FAIL reset_s_tready got=%b exp=0", s_if_p.tready); end
        rst = 1'b0;
        step();
        total++; if (s_if_p.tready !== 1'b1) begin bad++; $display("FAIL post_reset_s_tready got=%b exp=1", s_if_p.tready); end
        total++; if (state_p !== 1'b0) begin bad++; $display("FAIL post_reset_state got=%b exp=0", state_p); end
    endtask

    task automatic test_pair();
        s_tvalid = 1'b1; s_tdata = 8'h03; s_tlast = 1'b0;
        step();
        total++; if (m_if_p.tvalid !== 1'b0) begin bad++; $display("FAIL pair_half_valid got=%b exp=0", m_if_p.tvalid); end
        total++; if (state_p !== 1'b1) begin bad++; $display("FAIL pair_half_state got=%b exp=1", state_p); end
        s_tdata = 8'h05; s_tlast = 1'b1;
        step();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        total++; if (m_if_p.tvalid !== 1'b1) begin bad++; $display("FAIL pair_valid got=%b exp=1", m_if_p.tvalid); end
        total++; if (m_if_p.tdata !== 16'h0503) begin bad++; $display("FAIL pair_data got=%h exp=0503", m_if_p.tdata); end
        total++; if (m_if_p.tlast !== 1'b1) begin bad++; $display("FAIL pair_last got=%b exp=1", m_if_p.tlast); end
        step();
        total++; if (m_if_p.tvalid !== 1'b0) begin bad++; $display("FAIL pair_one_cycle got=%b exp=0", m_if_p.tvalid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_w;
        s_tvalid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_tdata = 8'(i);
            s_tlast = (i == 8);
            total++; if (s_if_p.tready !== 1'b1) begin bad++; $display("FAIL b2b_s_tready beat=%0d got=%b exp=1", i, s_if_p.tready); end
            step();
            if (i % 2 == 0) begin
                exp_w = {8'(i), 8'(i - 1)};
                total++; if (m_if_p.tvalid !== 1'b1 || m_if_p.tdata !== exp_w) begin
                    bad++; $display("FAIL b2b_pair beat=%0d got=%b/%h exp=1/%h", i, m_if_p.tvalid, m_if_p.tdata, exp_w);
                end
            end else begin
                total++; if (m_if_p.tvalid !== 1'b0) begin bad++; $display("FAIL b2b_gap beat=%0d got=%b exp=0", i, m_if_p.tvalid); end
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        step();
        total++; if (m_if_p.tvalid !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%b exp=0", m_if_p.tvalid); end
    endtask

    task automatic test_backpressure();
        s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1;
        s_tdata = 8'h01; step();
        s_tdata = 8'h02; step();
        total++; if (m_if_p.tdata !== 16'h0201 || m_if_p.tvalid !== 1'b1) begin
            bad++; $display("FAIL bp_first got=%b/%h exp=1/0201", m_if_p.tvalid, m_if_p.tdata);
        end
        m_tready = 1'b0; s_tdata = 8'h03;
        #1;
        total++; if (s_if_p.tready !== 1'b0) begin bad++; $display("FAIL bp_s_tready got=%b exp=0", s_if_p.tready); end
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if (m_if_p.tvalid !== 1'b1 || m_if_p.tdata !== 16'h0201) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/0201", k, m_if_p.tvalid, m_if_p.tdata);
            end
            total++; if (state_p !== 1'b0) begin bad++; $display("FAIL bp_not_accepted cyc=%0d got=%b exp=0", k, state_p); end
        end
        m_tready = 1'b1;
        #1;
        total++; if (s_if_p.tready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", s_if_p.tready); end
        step();
        total++; if (state_p !== 1'b1 || m_if_p.tvalid !== 1'b0) begin
            bad++; $display("FAIL bp_release got=state%b/valid%b exp=state1/valid0", state_p, m_if_p.tvalid);
        end
        s_tdata = 8'h04; s_tlast = 1'b1;
        step();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        total++; if (m_if_p.tdata !== 16'h0403 || m_if_p.tlast !== 1'b1) begin
            bad++; $display("FAIL bp_after got=%h/%b exp=0403/1", m_if_p.tdata, m_if_p.tlast);
        end
        step();
    endtask

    task automatic test_odd();
        s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1;
        s_tdata = 8'h11; step();
        s_tdata = 8'h22; step();
        total++; if (m_if_p.tdata !== 16'h2211 || m_if_p.tlast !== 1'b0 || m_if_p.tvalid !== 1'b1) begin
            bad++; $display("FAIL odd_pad_pair got=%b/%h/%b exp=1/2211/0", m_if_p.tvalid, m_if_p.tdata, m_if_p.tlast);
        end
        total++; if (m_if_d.tdata !== 16'h2211 || m_if_d.tvalid !== 1'b1) begin
            bad++; $display("FAIL odd_drop_pair got=%b/%h exp=1/2211", m_if_d.tvalid, m_if_d.tdata);
        end
        s_tdata = 8'h33; s_tlast = 1'b1; step();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        total++; if (m_if_p.tdata !== 16'h0033 || m_if_p.tlast !== 1'b1 || m_if_p.tvalid !== 1'b1) begin
            bad++; $display("FAIL odd_pad_lone got=%b/%h/%b exp=1/0033/1", m_if_p.tvalid, m_if_p.tdata, m_if_p.tlast);
        end
        total++; if (odd_drop_p !== 1'b0) begin bad++; $display("FAIL odd_pad_no_drop got=%b exp=0", odd_drop_p); end
        total++; if (m_if_d.tvalid !== 1'b0) begin bad++; $display("FAIL odd_drop_no_out got=%b exp=0", m_if_d.tvalid); end
        total++; if (odd_drop_d !== 1'b1) begin bad++; $display("FAIL odd_drop_pulse got=%b exp=1", odd_drop_d); end
        step();
        total++; if (odd_drop_d !== 1'b0) begin bad++; $display("FAIL odd_drop_single got=%b exp=0", odd_drop_d); end
        total++; if (m_if_d.tvalid !== 1'b0 || m_if_p.tvalid !== 1'b0) begin
            bad++; $display("FAIL odd_idle got=%b%b exp=00", m_if_p.tvalid, m_if_d.tvalid);
        end
    endtask

    task automatic test_reset_mid();
        s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = 8'hAA;
        step();
        total++; if (state_p !== 1'b1) begin bad++; $display("FAIL mid_half got=%b exp=1", state_p); end
        s_tvalid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (state_p !== 1'b0 || m_if_p.tvalid !== 1'b0) begin
            bad++; $display("FAIL mid_reset got=state%b/valid%b exp=state0/valid0", state_p, m_if_p.tvalid);
        end
        s_tvalid = 1'b1; s_tdata = 8'h01; step();
        total++; if (m_if_p.tvalid !== 1'b0) begin bad++; $display("FAIL mid_no_aa got=%b/%h exp=0", m_if_p.tvalid, m_if_p.tdata); end
        s_tdata = 8'h02; s_tlast = 1'b1; step();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        total++; if (m_if_p.tdata !== 16'h0201 || m_if_p.tvalid !== 1'b1 || m_if_p.tlast !== 1'b1) begin
            bad++; $display("FAIL mid_pair got=%b/%h/%b exp=1/0201/1", m_if_p.tvalid, m_if_p.tdata, m_if_p.tlast);
        end
        step();
        total++; if (m_if_p.tvalid !== 1'b0) begin bad++; $display("FAIL mid_end got=%b exp=0", m_if_p.tvalid); end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_back_to_back();
        test_backpressure();
        test_odd();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_operand_pairer.md
Name: axis_operand_pairer

Overview:
Upstream feeder for the two-operand AXI-Stream adder. Takes a stream of single c_WIDTH-bit operands and packs each two consecutive beats into one 2*c_WIDTH-bit word. The first beat goes in the low half and the second in the high half, which matches the adder's {b, a} operand layout. Handles odd-length packets, marked by tlast, by zero-padding or dropping the lone operand. Has a registered output and full backpressure support.

Parameters:
c_WIDTH, 8, width of one operand; output word is 2*c_WIDTH.
c_PAD_ODD, 1, 1 = lone last operand is emitted with high half zero; 0 = lone last operand is discarded.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
s_axis_tdata  input  c_WIDTH  operand in
s_axis_tvalid  input  1  operand valid
s_axis_tready  output  1  operand accepted when tvalid && tready
s_axis_tlast  input  1  last operand of packet
m_axis_tdata  output  2*c_WIDTH  packed pair {second, first}
m_axis_tvalid  output  1  pair valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  pair closes a packet
odd_drop  output  1  one-cycle pulse when a lone operand is discarded (c_PAD_ODD=0 only)

Behaviour:
- Reset (rst=1 at a clock edge):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, odd_drop=0.
  - State returns to EMPTY and the held operand register clears to 0.
  - Takes priority over every other event, including mid-pair. A held half-pair is lost, and no output is produced for it.
- States:
  - EMPTY: no operand held.
  - HALF: first operand held in lo_q.
- Output slot free: free = !m_axis_tvalid || m_axis_tready.
- s_axis_tready = free. This is combinational and is the same in both states. It is 0 during reset.
- Output drain: if m_axis_tvalid && m_axis_tready and no new pair is loaded that cycle, m_axis_tvalid <= 0.
- EMPTY, beat accepted, tlast=0:
  - lo_q <= tdata; go to HALF.
  - No output change except the drain.
- EMPTY, beat accepted, tlast=1 (lone operand):
  - c_PAD_ODD=1: m_axis_tdata <= {0, tdata}, m_axis_tlast <= 1, m_axis_tvalid <= 1. Stay in EMPTY.
  - c_PAD_ODD=0: no output. odd_drop <= 1 for one cycle. Stay in EMPTY.
- HALF, beat accepted:
  - m_axis_tdata <= {tdata, lo_q}, m_axis_tlast <= s_axis_tlast, m_axis_tvalid <= 1. Go to EMPTY.
- Latency: a pair appears on m_axis one cycle after its second operand is accepted.
- Throughput: one operand per cycle while downstream holds tready=1. Output drain and new load may happen in the same cycle.
- m_axis_tdata and m_axis_tlast hold stable while m_axis_tvalid=1 && m_axis_tready=0.
- Arithmetic: none. Bit placement is exact: first operand at [c_WIDTH-1:0], second at [2*c_WIDTH-1:c_WIDTH].
- A tlast arriving in HALF closes the packet normally. The next operand starts a fresh pair.
- s_axis_tvalid low in HALF: lo_q is held indefinitely, with no timeout.
- odd_drop is 0 in every cycle not listed above.

Test Plan:
1. Reset → all outputs 0. Drive operands 0x03, 0x05 (tlast on 0x05) with m_axis_tready=1 → one cycle after 0x05 is accepted: m_axis_tdata=0x0503, tlast=1, tvalid high for exactly 1 cycle.
2. Back-to-back stream 0x01..0x08, m_axis_tready=1 → s_axis_tready stays 1 throughout; outputs are 0x0201, 0x0403, 0x0605, 0x0807 on consecutive alternate cycles.
3. Backpressure: hold m_axis_tready=0 after pair 0x0201 is produced → s_axis_tready=0, output is stable, and operand 0x03 is not accepted. Release tready → 0x0201 handshakes, then 0x03 is accepted in that same cycle.
4. Odd packet, c_PAD_ODD=1: operands 0x11, 0x22, 0x33 (tlast on 0x33) → outputs 0x2211 (tlast=0), then 0x0033 (tlast=1).
5. Odd packet, c_PAD_ODD=0: same stimulus → only 0x2211 is output; odd_drop pulses once, in the cycle after 0x33 is accepted.
6. Reset mid-pair: accept 0xAA, then assert rst for 1 cycle, then send 0x01, 0x02 → output is 0x0201; 0xAA never appears.
